// File: rtl/port_b_bias_capture.sv
// port_b_bias_capture
//
// Receiving end of the BRAM port-B fetch path. Each request puts two consecutive
// words on dout_b. Word 0 arrives with port_b_start_out and word 1 follows one
// cycle later. port_b_done then closes the transfer.
//
// A neuron fetch is delivered as a one-cycle deliver_valid pulse. The pulse
// carries a one-hot neuron_sel and the two captured words. A boot fetch loads
// the persistent bias registers instead, and leaves the neuron outputs untouched.
//
// Ports:
//   clk              in   system clock
//   rst_n            in   synchronous active-low reset
//   boot_mode        in   current fetch is the bias pair (sampled with start)
//   port_b_start_out in   pulse, word 0 valid on dout_b this cycle
//   port_b_done      in   pulse, payload transfer complete
//   dout_b           in   BRAM port-B read data
//   neuron_id        in   index of neuron being served (sampled with start)
//   word0_out        out  captured first word, held until the next delivery
//   word1_out        out  captured second word, held until the next delivery
//   neuron_sel       out  one-hot target, non-zero only with deliver_valid
//   deliver_valid    out  one-cycle pulse, words ready for neuron_sel
//   bias0            out  boot-loaded bias word 0
//   bias1            out  boot-loaded bias word 1
//   bias_loaded      out  sticky, set after the first boot capture
//   proto_err        out  sticky protocol-error flag
//   busy             out  high whenever the capture FSM is not idle

module port_b_bias_capture #(
   parameter int unsigned NUM_NEURONS = 30,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ID_W        = 5,
   parameter int unsigned TIMEOUT     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   boot_mode,
   input  logic                   port_b_start_out,
   input  logic                   port_b_done,
   input  logic [DATA_W-1:0]      dout_b,
   input  logic [ID_W-1:0]        neuron_id,
   output logic [DATA_W-1:0]      word0_out,
   output logic [DATA_W-1:0]      word1_out,
   output logic [NUM_NEURONS-1:0] neuron_sel,
   output logic                   deliver_valid,
   output logic [DATA_W-1:0]      bias0,
   output logic [DATA_W-1:0]      bias1,
   output logic                   bias_loaded,
   output logic                   proto_err,
   output logic                   busy
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StCap1,
      StWaitDone,
      StEmit
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [CntW-1:0]        cnt_inc;

   // Capture buffer, filled during CAP1.
   logic [DATA_W-1:0]      cap_w0_q, cap_w0_d;
   logic [DATA_W-1:0]      cap_w1_q, cap_w1_d;
   logic [ID_W-1:0]        tag_id_q, tag_id_d;
   logic                   tag_boot_q, tag_boot_d;

   // Output registers.
   logic [DATA_W-1:0]      word0_q, word0_d;
   logic [DATA_W-1:0]      word1_q, word1_d;
   logic [NUM_NEURONS-1:0] sel_q, sel_d;
   logic                   dv_q, dv_d;
   logic [DATA_W-1:0]      bias0_q, bias0_d;
   logic [DATA_W-1:0]      bias1_q, bias1_d;
   logic                   loaded_q, loaded_d;
   logic                   err_q, err_d;

   logic                   id_in_range;

   assign cnt_inc     = cnt_q + 1'b1;
   assign id_in_range = (32'(tag_id_q) < NUM_NEURONS);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_w0_d   = cap_w0_q;
      cap_w1_d   = cap_w1_q;
      tag_id_d   = tag_id_q;
      tag_boot_d = tag_boot_q;
      word0_d    = word0_q;
      word1_d    = word1_q;
      sel_d      = '0;
      dv_d       = 1'b0;
      bias0_d    = bias0_q;
      bias1_d    = bias1_q;
      loaded_d   = loaded_q;
      err_d      = err_q;

      unique case (state_q)
         StIdle: begin
            if (port_b_done) begin
               err_d = 1'b1;
            end
            if (port_b_start_out) begin
               cap_w0_d   = dout_b;
               tag_id_d   = neuron_id;
               tag_boot_d = boot_mode;
               state_d    = StCap1;
            end
         end

         StCap1: begin
            if (port_b_start_out) begin
               // Restart: abandon the current capture and take the new word 0.
               err_d      = 1'b1;
               cap_w0_d   = dout_b;
               tag_id_d   = neuron_id;
               tag_boot_d = boot_mode;
               state_d    = StCap1;
            end else begin
               cap_w1_d = dout_b;
               cnt_d    = '0;
               state_d  = StWaitDone;
            end
         end

         StWaitDone: begin
            if (port_b_start_out) begin
               // A start beats a coincident done, so the old capture is dropped.
               err_d      = 1'b1;
               cap_w0_d   = dout_b;
               tag_id_d   = neuron_id;
               tag_boot_d = boot_mode;
               state_d    = StCap1;
            end else if (port_b_done) begin
               // Outputs load here so that they are visible during the EMIT cycle.
               state_d = StEmit;
               if (tag_boot_q) begin
                  bias0_d  = cap_w0_q;
                  bias1_d  = cap_w1_q;
                  loaded_d = 1'b1;
               end else if (id_in_range) begin
                  dv_d    = 1'b1;
                  sel_d   = NUM_NEURONS'(1) << tag_id_q;
                  word0_d = cap_w0_q;
                  word1_d = cap_w1_q;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CntW'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = StIdle;
               end
            end
         end

         StEmit: begin
            // The pulse is already on the outputs. A new start here begins the
            // next capture without an idle cycle in between.
            state_d = StIdle;
            if (port_b_start_out) begin
               cap_w0_d   = dout_b;
               tag_id_d   = neuron_id;
               tag_boot_d = boot_mode;
               state_d    = StCap1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         cap_w0_q   <= '0;
         cap_w1_q   <= '0;
         tag_id_q   <= '0;
         tag_boot_q <= 1'b0;
         word0_q    <= '0;
         word1_q    <= '0;
         sel_q      <= '0;
         dv_q       <= 1'b0;
         bias0_q    <= '0;
         bias1_q    <= '0;
         loaded_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_w0_q   <= cap_w0_d;
         cap_w1_q   <= cap_w1_d;
         tag_id_q   <= tag_id_d;
         tag_boot_q <= tag_boot_d;
         word0_q    <= word0_d;
         word1_q    <= word1_d;
         sel_q      <= sel_d;
         dv_q       <= dv_d;
         bias0_q    <= bias0_d;
         bias1_q    <= bias1_d;
         loaded_q   <= loaded_d;
         err_q      <= err_d;
      end
   end

   assign word0_out     = word0_q;
   assign word1_out     = word1_q;
   assign neuron_sel    = sel_q;
   assign deliver_valid = dv_q;
   assign bias0         = bias0_q;
   assign bias1         = bias1_q;
   assign bias_loaded   = loaded_q;
   assign proto_err     = err_q;
   assign busy          = (state_q != StIdle);

endmodule
